aes256_inv_key_sched: RTL and testbench
=======================================

# aes256_inv_key_sched

Reverse-direction AES-256 key schedule for the decryption datapath. It is loaded with the last two round keys (K14, K13) and regenerates every round key in descending order, K14 down to K0, one per handshake beat. The block runs the forward expansion recurrence backwards and generates the round constants internally in descending order (0x40 down to 0x01). Its output feeds the inverse-cipher round pipeline, which consumes keys in decryption order.

## Interface
Parameters:
- none (AES-256 fixed: 15 round keys, 128-bit each)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  load request; sampled only in IDLE
- key_hi  input  128  round key K14 (words w56..w59, w56 in [127:96])
- key_lo  input  128  round key K13 (words w52..w55)
- busy  output  1  high from the cycle after start is accepted until the done cycle, inclusive
- rk_valid  output  1  rk_out/rk_idx valid
- rk_ready  input  1  consumer accepts the current key
- rk_out  output  128  current round key, same word ordering as the inputs
- rk_idx  output  4  round index of rk_out (14..0)
- done  output  1  single-cycle pulse after K0 is accepted

## Operation
- State: 256-bit window {hi, lo} = {K[k], K[k-1]}; 4-bit k; FSM states IDLE, RUN, DONE.
- IDLE → RUN when start=1: hi←key_hi, lo←key_lo, k←14. start is ignored outside IDLE.
- RUN: rk_out=hi, rk_idx=k, rk_valid=1. Nothing changes while rk_ready=0; rk_out and rk_idx stay stable.
- An accept is a cycle with rk_valid&rk_ready=1. On accept:
  - k≥2: hi←lo; lo←K[k-2]; k←k-1.
  - k=1: hi←lo; k←0; lo is don't-care.
  - k=0: go to DONE.
- K[k-2] is computed combinationally from the window. Let i=4k+t for t=0..3, and let w[j] be the window words.
  - w[i-8] = w[i] ^ f(w[i-1]).
  - t=0, k even: f = SubWord(RotWord(x)) ^ {Rcon, 24'h0}, with Rcon = 8'h01 << (k/2-1), so k=14 gives 0x40 and k=2 gives 0x01.
  - t=0, k odd: f = SubWord(x).
  - t=1..3: f = x, where x is w[i-1]. For t≥1 this is a word of hi, never a freshly computed word.
- RotWord rotates left by one byte. SubWord uses 4 instances of the team's forward S-box.
- DONE: done=1 for exactly one cycle, rk_valid=0, then IDLE. A start seen in DONE is ignored.

## Timing
- Reset values: busy=0, rk_valid=0, done=0, rk_out=0, rk_idx=0, FSM=IDLE, window cleared.
- rst=1 mid-operation aborts immediately. The next cycle shows the reset values, and no partial done pulse is produced.
- start accepted at cycle N:
  - cycle N+1: rk_valid=1, rk_idx=14, busy=1.
  - With rk_ready held high, throughput is 1 key/cycle: idx 14..0 in cycles N+1..N+15.
  - done=1 and busy=1 in cycle N+16.
  - Cycle N+17: busy=0, and start is accepted again.
- Backpressure: each rk_ready=0 cycle adds exactly one cycle, with no loss or duplication of keys.
- Critical path: S-box plus two 32-bit XORs per cycle. No internal pipelining; outputs are registered.

## Test plan
- FIPS-197 C.3 vector, rk_ready=1:
  - Inputs: key_hi=24fc79ccbf0979e9371ac23c6d68de36, key_lo=4e5a6699a9f24fe07e572baacdf8cdea.
  - Expected: rk_idx counts 14..0 in consecutive cycles. K1=101112131415161718191a1b1c1d1e1f, K0=000102030405060708090a0b0c0d0e0f. done pulses exactly once, at N+16.
  - Every key matches a software forward expansion.
- Same vector with random rk_ready (~40% high):
  - Identical 15-key sequence with no gaps or repeats; rk_out and rk_idx stay stable while stalled.
  - done arrives exactly 1 cycle after the K0 accept.
- start pulsed at idx 7 mid-run (and again during DONE): ignored; the sequence completes unchanged.
- rst asserted while rk_idx=5 with rk_valid=1: the next cycle shows all outputs at 0 and no done. A fresh start then reproduces the full correct sequence.
- Back-to-back runs: start in cycle N+17 with a random 256-bit key pair. K0/K1 expanded forward in the model must regenerate the given K13/K14.

Source files
------------

// File: rtl/aes256_inv_key_sched.sv
// Reverse AES-256 key schedule. It is loaded with K14/K13 and emits the
// round keys K14 down to K0, one per accepted handshake beat, by running
// the forward expansion recurrence backwards.
//
// Handshake: a key transfers in any cycle where rk_valid and rk_ready are
// both high. While rk_valid is high and rk_ready is low, rk_out and rk_idx
// hold steady. rk_valid never drops without a transfer.
module aes256_inv_key_sched (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [127:0] key_hi,
   input  logic [127:0] key_lo,
   output logic         busy,
   output logic         rk_valid,
   input  logic         rk_ready,
   output logic [127:0] rk_out,
   output logic [3:0]   rk_idx,
   output logic         done
);

   // Forward S-box, entry 0x00 in the top byte. Byte x is at bit offset 8*(255-x).
   localparam logic [2047:0] SBOX_BITS = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   // 255-x is simply ~x, so the bit offset is {~x, 3'b000}.
   function automatic logic [7:0] sbox(input logic [7:0] x);
      return SBOX_BITS[{~x, 3'b000} +: 8];
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] x);
      return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
   endfunction

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state;
   state_t        state_next;
   logic [127:0]  hi;        // K[k]
   logic [127:0]  lo;        // K[k-1]
   logic [3:0]    k;
   logic          accept;
   logic [7:0]    rcon;
   logic [31:0]   f0;
   logic [127:0]  key_prev;  // K[k-2]

   // A key transfers on this clock edge.
   always_comb accept = (state == RUN) && rk_ready;

   // Regenerate K[k-2] from the window. Word 0 depends on the last word of
   // lo; words 1..3 only use words of hi, so there is one S-box layer.
   always_comb begin
      // k/2-1 wraps for k<2; the result is unused there.
      rcon = 8'h01 << (k[3:1] - 3'd1);
      if (!k[0]) f0 = sub_word({lo[23:0], lo[31:24]}) ^ {rcon, 24'h0};
      else       f0 = sub_word(lo[31:0]);
      key_prev[127:96] = hi[127:96] ^ f0;
      key_prev[95:64]  = hi[95:64]  ^ hi[127:96];
      key_prev[63:32]  = hi[63:32]  ^ hi[95:64];
      key_prev[31:0]   = hi[31:0]   ^ hi[63:32];
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Next-state logic; start only matters in IDLE.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = RUN;
         RUN:     if (accept && (k == 4'd0)) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Key window and round index: load on start, slide down on each accept.
   always_ff @(posedge clk) begin
      if (rst) begin
         hi <= '0;
         lo <= '0;
         k  <= '0;
      end else if ((state == IDLE) && start) begin
         hi <= key_hi;
         lo <= key_lo;
         k  <= 4'd14;
      end else if (accept && (k != 4'd0)) begin
         hi <= lo;
         lo <= key_prev;
         k  <= k - 4'd1;
      end
   end

   // Outputs decoded from registered state only.
   always_comb begin
      busy     = (state != IDLE);
      rk_valid = (state == RUN);
      done     = (state == DONE);
      rk_out   = hi;
      rk_idx   = k;
   end

endmodule

// File: tb/tb_aes256_inv_key_sched.sv
// Bench for aes256_inv_key_sched: forward-expansion model with a GF(2^8)
// computed S-box, expected keys queued at start and popped on each accept.
module tb_aes256_inv_key_sched;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [127:0] key_hi;
   logic [127:0] key_lo;
   logic         busy;
   logic         rk_valid;
   logic         rk_ready;
   logic [127:0] rk_out;
   logic [3:0]   rk_idx;
   logic         done;

   int errors = 0;
   int checks = 0;

   // {idx, key} in expected output order
   logic [131:0] exp_q[$];

   localparam logic [255:0] FIPS_KEY =
      256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] FIPS_K14 = 128'h24fc79ccbf0979e9371ac23c6d68de36;
   localparam logic [127:0] FIPS_K13 = 128'h4e5a6699a9f24fe07e572baacdf8cdea;

   aes256_inv_key_sched dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .key_hi   (key_hi),
      .key_lo   (key_lo),
      .busy     (busy),
      .rk_valid (rk_valid),
      .rk_ready (rk_ready),
      .rk_out   (rk_out),
      .rk_idx   (rk_idx),
      .done     (done)
   );

   // clock
   always #5 clk = ~clk;

   // ---------------- model ----------------
   function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] p;
      logic       h;
      a = a_in;
      b = b_in;
      p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         h = a[7];
         a = a << 1;
         if (h) a = a ^ 8'h1b;
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] sbox_model(input logic [7:0] x);
      logic [7:0] inv;
      logic [7:0] s;
      inv = 8'h01;
      for (int i = 0; i < 254; i++) inv = gmul(inv, x);
      if (x == 8'h00) inv = 8'h00;
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
          {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      return s;
   endfunction

   function automatic logic [31:0] sub_word_model(input logic [31:0] x);
      return {sbox_model(x[31:24]), sbox_model(x[23:16]),
              sbox_model(x[15:8]), sbox_model(x[7:0])};
   endfunction

   // Forward AES-256 expansion; returns round key r (0..14).
   function automatic logic [127:0] fwd_rk(input logic [255:0] key, input int r);
      logic [31:0] w[60];
      logic [31:0] t;
      logic [7:0]  rc;
      for (int i = 0; i < 8; i++) w[i] = key[255 - 32*i -: 32];
      for (int i = 8; i < 60; i++) begin
         t = w[i-1];
         if (i % 8 == 0) begin
            rc = 8'h01 << (i/8 - 1);
            t = sub_word_model({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
         end else if (i % 8 == 4) begin
            t = sub_word_model(t);
         end
         w[i] = w[i-8] ^ t;
      end
      return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endfunction

   // ---------------- scoreboard ----------------
   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic push_expected(input logic [255:0] key);
      for (int r = 14; r >= 0; r--) exp_q.push_back({4'(r), fwd_rk(key, r)});
   endtask

   // ---------------- driver ----------------
   // Called at a negedge with the DUT idle; key_hi/key_lo already set and
   // exp_q filled. Returns at the negedge of the cycle after done
   // (or after the reset when aborting).
   task automatic run_seq(input int pct, input bit poke_mid, input bit poke_done,
                          input int abort_idx);
      int           cyc;
      bit           finished;
      logic [131:0] head;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 1;
      check("first_busy", 128'(busy), 128'(1'b1));
      check("first_idx", 128'(rk_idx), 128'(4'd14));
      finished = 1'b0;
      while (!finished) begin
         if (cyc > 300) begin
            checks++;
            errors++;
            $error("FAIL timeout: waited %0d cycles, keys left %0d, required 0", cyc, exp_q.size());
            exp_q.delete();
            return;
         end
         rk_ready = ($urandom_range(0, 99) < pct);
         check("valid", 128'(rk_valid), 128'(1'b1));
         head = exp_q[0];
         check("key", rk_out, head[127:0]);
         check("idx", 128'(rk_idx), 128'(head[131:128]));
         check("done_early", 128'(done), 128'(1'b0));
         if ((abort_idx >= 0) && (int'(head[131:128]) == abort_idx)) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check("rst_busy", 128'(busy), 128'(1'b0));
            check("rst_valid", 128'(rk_valid), 128'(1'b0));
            check("rst_done", 128'(done), 128'(1'b0));
            check("rst_out", rk_out, 128'h0);
            check("rst_idx", 128'(rk_idx), 128'(4'd0));
            exp_q.delete();
            @(negedge clk);
            check("rst_done_after", 128'(done), 128'(1'b0));
            check("rst_busy_after", 128'(busy), 128'(1'b0));
            return;
         end
         if (poke_mid) start = (head[131:128] == 4'd7);
         if (rk_ready) void'(exp_q.pop_front());
         if (rk_ready && (exp_q.size() == 0)) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            check("done_pulse", 128'(done), 128'(1'b1));
            check("done_busy", 128'(busy), 128'(1'b1));
            check("done_valid", 128'(rk_valid), 128'(1'b0));
            if (pct >= 100) check("done_cycle", 128'(cyc), 128'(16));
            if (poke_done) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check("after_done", 128'(done), 128'(1'b0));
            check("after_busy", 128'(busy), 128'(1'b0));
            check("after_valid", 128'(rk_valid), 128'(1'b0));
            finished = 1'b1;
         end else begin
            @(negedge clk);
            cyc++;
         end
      end
   endtask

   // ---------------- directed steps ----------------
   initial begin
      logic [255:0] rkey;
      rst      = 1'b1;
      start    = 1'b0;
      rk_ready = 1'b0;
      key_hi   = '0;
      key_lo   = '0;
      repeat (3) @(negedge clk);
      check("reset_busy", 128'(busy), 128'(1'b0));
      check("reset_valid", 128'(rk_valid), 128'(1'b0));
      check("reset_done", 128'(done), 128'(1'b0));
      check("reset_out", rk_out, 128'h0);
      check("reset_idx", 128'(rk_idx), 128'(4'd0));
      rst = 1'b0;
      @(negedge clk);

      // FIPS vector, full throughput, start poked during DONE
      key_hi = FIPS_K14;
      key_lo = FIPS_K13;
      push_expected(FIPS_KEY);
      run_seq(100, 1'b0, 1'b1, -1);

      // same vector, random backpressure, start poked at idx 7
      push_expected(FIPS_KEY);
      run_seq(40, 1'b1, 1'b0, -1);

      // abort with reset at idx 5
      push_expected(FIPS_KEY);
      run_seq(100, 1'b0, 1'b0, 5);

      // fresh run after the abort
      push_expected(FIPS_KEY);
      run_seq(100, 1'b0, 1'b0, -1);

      // back-to-back random key pairs
      for (int n = 0; n < 2; n++) begin
         for (int j = 0; j < 8; j++) rkey[32*j +: 32] = $urandom;
         key_hi = fwd_rk(rkey, 14);
         key_lo = fwd_rk(rkey, 13);
         push_expected(rkey);
         run_seq((n == 0) ? 100 : 40, 1'b0, 1'b0, -1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
